// File: rtl/fib_sequencer.sv
// -----------------------------------------------------------------------------
// fib_sequencer
//
// Control sequencer for the basic CPU datapath. After an accepted start it
// writes two seed values into the register file through the immediate bus
// path, then issues ADD operations so that every following register receives
// the sum of the two previously written registers (a Fibonacci-style run).
// Register indices wrap modulo 2^REG_AW, so runs may be longer than the
// register file. The sequencer only steers selects and enables; all data
// arithmetic happens in the ALU.
//
// Optional feature macro: FIBSEQ_OVF_STOP_EN
//   When defined, an ALU carry-out during an ADD term ends the run early
//   (the carrying write still commits) and raises the sticky `ovf` output.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle run request, accepted only in IDLE
//   seed0/seed1 in   first/second term, latched on accepted start
//   count       in   total terms to write (seeds included), latched on start
//   aluCarry    in   ALU carry-out (used only with FIBSEQ_OVF_STOP_EN)
//   initialR    out  immediate value for the register-file write bus
//   regWrite    out  register-file write select
//   regRead1    out  read select A (newer operand)
//   regRead2    out  read select B (older operand)
//   ALUOp       out  ALU operation (NOP / ADD)
//   buffCtrl    out  bus buffers: 0001 immediate, 1110 ALU, 0000 no driver
//   regWriteEn  out  register-file write enable
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at the end of a run
//   ovf         out  sticky overflow flag (only with FIBSEQ_OVF_STOP_EN)
//
// All outputs are registered: the decode is computed from next-state values
// so each output appears in the same cycle as the state it belongs to.
// -----------------------------------------------------------------------------
module fib_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 8,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  input  logic [CNT_W-1:0]  count,
  input  logic              aluCarry,
  output logic [DATA_W-1:0] initialR,
  output logic [REG_AW-1:0] regWrite,
  output logic [REG_AW-1:0] regRead1,
  output logic [REG_AW-1:0] regRead2,
  output logic [OP_W-1:0]   ALUOp,
  output logic [3:0]        buffCtrl,
  output logic              regWriteEn,
  output logic              busy,
  output logic              done
`ifdef FIBSEQ_OVF_STOP_EN
  ,
  output logic              ovf
`endif
);

  // Opcode values of the shared opcode include (NOP must be zero so that the
  // reset state of every output is all-zero).
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);

  localparam logic [3:0] BUF_NONE = 4'b0000;
  localparam logic [3:0] BUF_IMM  = 4'b0001;
  localparam logic [3:0] BUF_ALU  = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED0 = 3'd1,
    S_SEED1 = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_k;
  logic [CNT_W-1:0]    w_k_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [DATA_W-1:0]   r_seed0;
  logic [DATA_W-1:0]   w_seed0_nxt;
  logic [DATA_W-1:0]   r_seed1;
  logic [DATA_W-1:0]   w_seed1_nxt;
  logic                w_stop_s;

  // Decoded (pre-register) output values
  logic [DATA_W-1:0]   w_initial;
  logic [REG_AW-1:0]   w_wr_sel;
  logic [REG_AW-1:0]   w_rd1_sel;
  logic [REG_AW-1:0]   w_rd2_sel;
  logic [OP_W-1:0]     w_op;
  logic [3:0]          w_buf;
  logic                w_wr_en;
  logic                w_busy;
  logic                w_done;

`ifdef FIBSEQ_OVF_STOP_EN
  logic                r_ovf;
  logic                w_ovf_nxt;

  // Carry seen during an ADD term ends the run after that term's write.
  assign w_stop_s = aluCarry;
`else
  logic                w_unused_carry;

  assign w_unused_carry = aluCarry;
  assign w_stop_s       = 1'b0;
`endif

  // Next-state logic: run control, term counter and latched run parameters.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_count_nxt = r_count;
    w_seed0_nxt = r_seed0;
    w_seed1_nxt = r_seed1;
`ifdef FIBSEQ_OVF_STOP_EN
    w_ovf_nxt   = r_ovf;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_seed0_nxt = seed0;
          w_seed1_nxt = seed1;
          w_count_nxt = count;
          w_k_nxt     = CNT_W'(0);
`ifdef FIBSEQ_OVF_STOP_EN
          w_ovf_nxt   = 1'b0;
`endif
          if (count == CNT_W'(0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SEED0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEED0: begin
        if (r_count == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SEED1;
        end
      end
      S_SEED1: begin
        if (r_count == CNT_W'(2)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ADD;
          w_k_nxt     = CNT_W'(2);
        end
      end
      S_ADD: begin
        // The term being written now is r_k; the last one is count-1.
        if (w_stop_s) begin
          w_state_nxt = S_DONE;
`ifdef FIBSEQ_OVF_STOP_EN
          w_ovf_nxt   = 1'b1;
`endif
        end else if (r_k == (r_count - CNT_W'(1))) begin
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt     = r_k + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore output decode of the next state, registered below.
  always_comb begin
    w_initial = {DATA_W{1'b0}};
    w_wr_sel  = {REG_AW{1'b0}};
    w_rd1_sel = {REG_AW{1'b0}};
    w_rd2_sel = {REG_AW{1'b0}};
    w_op      = OP_NOP;
    w_buf     = BUF_NONE;
    w_wr_en   = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (w_state_nxt)
      S_SEED0: begin
        w_initial = w_seed0_nxt;
        w_wr_sel  = REG_AW'(0);
        w_buf     = BUF_IMM;
        w_wr_en   = 1'b1;
        w_busy    = 1'b1;
      end
      S_SEED1: begin
        w_initial = w_seed1_nxt;
        w_wr_sel  = REG_AW'(1);
        w_buf     = BUF_IMM;
        w_wr_en   = 1'b1;
        w_busy    = 1'b1;
      end
      S_ADD: begin
        // Truncation to REG_AW bits gives the modular register index.
        w_wr_sel  = w_k_nxt[REG_AW-1:0];
        w_rd1_sel = w_k_nxt[REG_AW-1:0] - REG_AW'(1);
        w_rd2_sel = w_k_nxt[REG_AW-1:0] - REG_AW'(2);
        w_op      = OP_ADD;
        w_buf     = BUF_ALU;
        w_wr_en   = 1'b1;
        w_busy    = 1'b1;
      end
      S_DONE: begin
        w_done    = 1'b1;
        w_busy    = 1'b1;
      end
      S_IDLE: begin
        w_busy    = 1'b0;
      end
      default: begin
        w_busy    = 1'b0;
      end
    endcase
  end

  // State, run parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= CNT_W'(0);
      r_count    <= CNT_W'(0);
      r_seed0    <= {DATA_W{1'b0}};
      r_seed1    <= {DATA_W{1'b0}};
      initialR   <= {DATA_W{1'b0}};
      regWrite   <= {REG_AW{1'b0}};
      regRead1   <= {REG_AW{1'b0}};
      regRead2   <= {REG_AW{1'b0}};
      ALUOp      <= OP_NOP;
      buffCtrl   <= BUF_NONE;
      regWriteEn <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef FIBSEQ_OVF_STOP_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_count    <= w_count_nxt;
      r_seed0    <= w_seed0_nxt;
      r_seed1    <= w_seed1_nxt;
      initialR   <= w_initial;
      regWrite   <= w_wr_sel;
      regRead1   <= w_rd1_sel;
      regRead2   <= w_rd2_sel;
      ALUOp      <= w_op;
      buffCtrl   <= w_buf;
      regWriteEn <= w_wr_en;
      busy       <= w_busy;
      done       <= w_done;
`ifdef FIBSEQ_OVF_STOP_EN
      r_ovf      <= w_ovf_nxt;
`endif
    end
  end

`ifdef FIBSEQ_OVF_STOP_EN
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fib_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fib_sequencer
//
// Scoreboard bench. A driver issues runs and pushes the expected register-file
// writes and done pulse (with their cycle numbers) into queues, computed from
// a term list built with plain arithmetic. A monitor compares every write and
// done pulse the DUT presents, plus busy and idle outputs every cycle. A small
// register-file/ALU model is driven by the DUT outputs so stored values can be
// checked against the arithmetic term list.
// -----------------------------------------------------------------------------
module tb_fib_sequencer;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] ADD = 8'h01;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] seed0;
  logic [15:0] seed1;
  logic [7:0]  count;
  logic        alu_carry;
  logic [15:0] initialR;
  logic [3:0]  regWrite;
  logic [3:0]  regRead1;
  logic [3:0]  regRead2;
  logic [7:0]  ALUOp;
  logic [3:0]  buffCtrl;
  logic        regWriteEn;
  logic        busy;
  logic        done;
`ifdef FIBSEQ_OVF_STOP_EN
  logic        ovf;
`endif

  fib_sequencer #(.DATA_W(16), .REG_AW(4), .CNT_W(8), .OP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .count(count), .aluCarry(alu_carry), .initialR(initialR),
    .regWrite(regWrite), .regRead1(regRead1), .regRead2(regRead2),
    .ALUOp(ALUOp), .buffCtrl(buffCtrl), .regWriteEn(regWriteEn),
    .busy(busy), .done(done)
`ifdef FIBSEQ_OVF_STOP_EN
    , .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file + ALU model driven by the sequencer's selects.
  logic [15:0] rf [16];
  initial for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
  always @(posedge clk) begin
    if (regWriteEn === 1'b1) begin
      if (buffCtrl == 4'b0001) rf[regWrite] <= initialR;
      else if (buffCtrl == 4'b1110) rf[regWrite] <= rf[regRead1] + rf[regRead2];
      else rf[regWrite] <= 16'hxxxx;
    end
  end
  assign alu_carry = (({1'b0, rf[regRead1]} + {1'b0, rf[regRead2]}) > 17'h0FFFF);

  typedef struct {
    int          cyc;
    logic [3:0]  wr;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  buff;
    logic [7:0]  op;
    logic [15:0] imm;
  } wr_t;

  wr_t exp_wr_q[$];
  int  exp_done_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  int  busy_lo = 1;
  int  busy_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pops expected writes / done pulses as the DUT presents them.
  wr_t m_e;
  int  m_d;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (regWriteEn !== 1'b0) begin
        chk("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          m_e = exp_wr_q.pop_front();
          chk("write_cycle", cyc, m_e.cyc);
          chk("regWrite", 32'(regWrite), 32'(m_e.wr));
          if (m_e.buff == 4'b1110) begin
            chk("regRead1", 32'(regRead1), 32'(m_e.r1));
            chk("regRead2", 32'(regRead2), 32'(m_e.r2));
          end
          chk("buffCtrl", 32'(buffCtrl), 32'(m_e.buff));
          chk("ALUOp", 32'(ALUOp), 32'(m_e.op));
          chk("initialR", 32'(initialR), 32'(m_e.imm));
        end
      end else begin
        chk("idle_selects", {16'h0, regWrite, regRead1, regRead2, buffCtrl}, 32'h0);
        chk("idle_op_imm", {8'h0, ALUOp, initialR}, {8'h0, NOP, 16'h0000});
      end
      if (done !== 1'b0) begin
        chk("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
        if (exp_done_q.size() != 0) begin
          m_d = exp_done_q.pop_front();
          chk("done_cycle", cyc, m_d);
        end
      end
    end
  end

  // One run: reference terms, expectations, stimulus, end-of-run checks.
  // ign_at: cycle in which a stray start pulse is driven (-1 none).
  // rst_at: cycle in which reset is asserted (-1 none).
  task automatic run(input logic [15:0] s0, input logic [15:0] s1, input int cnt,
                     input int ign_at, input int rst_at);
    logic [15:0] t[$];
    int  n;
    int  sum;
    int  e0;
    int  cut;
    int  nw;
    bit  stop;
    wr_t e;
    n = 0;
    stop = 1'b0;
    for (int j = 0; j < cnt && !stop; j++) begin
      if (j == 0) t.push_back(s0);
      else if (j == 1) t.push_back(s1);
      else begin
        sum = int'(t[j-1]) + int'(t[j-2]);
        t.push_back(16'(sum));
`ifdef FIBSEQ_OVF_STOP_EN
        if (sum > 65535) stop = 1'b1;
`endif
      end
      n++;
    end
    @(negedge clk);
    seed0 = s0; seed1 = s1; count = 8'(cnt); start = 1'b1;
    e0  = cyc + 1;
    cut = (rst_at > 0) ? rst_at : 1000000;
    for (int j = 0; j < n; j++) begin
      if (j + 1 <= cut) begin
        e.cyc  = e0 + j;
        e.wr   = 4'(j % 16);
        e.r1   = 4'((j + 15) % 16);
        e.r2   = 4'((j + 14) % 16);
        e.buff = (j < 2) ? 4'b0001 : 4'b1110;
        e.op   = (j < 2) ? NOP : ADD;
        e.imm  = (j == 0) ? s0 : ((j == 1) ? s1 : 16'h0000);
        exp_wr_q.push_back(e);
      end
    end
    if (n + 1 <= cut) exp_done_q.push_back(e0 + n);
    busy_lo = e0;
    busy_hi = (n + 1 <= cut) ? (e0 + n) : (e0 + cut - 1);
    @(negedge clk);
    start = 1'b0;
    seed0 = ~s0; seed1 = ~s1; count = 8'($urandom_range(0, 255));
`ifdef FIBSEQ_OVF_STOP_EN
    chk("ovf_cleared_on_start", 32'(ovf), 32'd0);
`endif
    while (cyc < e0 + n + 3) begin
      start = (cyc == e0 + ign_at - 1) ? 1'b1 : 1'b0;
      reset = (cyc == e0 + rst_at - 1) ? 1'b1 : 1'b0;
      if (start) begin
        seed0 = 16'($urandom); seed1 = 16'($urandom); count = 8'd3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
    chk("writes_drained", exp_wr_q.size(), 32'd0);
    chk("done_drained", exp_done_q.size(), 32'd0);
    nw = (n < cut) ? n : cut;
    for (int j = ((nw > 16) ? nw - 16 : 0); j < nw; j++)
      chk("rf_value", 32'(rf[j % 16]), 32'(t[j]));
`ifdef FIBSEQ_OVF_STOP_EN
    if (rst_at < 0) chk("ovf_held", 32'(ovf), 32'(stop));
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed0 = 16'h0; seed1 = 16'h0; count = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wren", 32'(regWriteEn), 32'd0);
    chk("rst_selects", {16'h0, regWrite, regRead1, regRead2, buffCtrl}, 32'h0);
    chk("rst_op_imm", {8'h0, ALUOp, initialR}, {8'h0, NOP, 16'h0000});
`ifdef FIBSEQ_OVF_STOP_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;
    mon_en = 1'b1;

    run(16'd0, 16'd1, 10, -1, -1);
    chk("fib_R9_is_34", 32'(rf[9]), 32'd34);
    run(16'd0, 16'd1, 20, -1, -1);
    chk("fib_R3_is_4181", 32'(rf[3]), 32'd4181);
    run(16'd5, 16'd7, 0, -1, -1);
    run(16'd9, 16'd8, 1, -1, -1);
    run(16'd11, 16'd13, 2, -1, -1);
    run(16'd2, 16'd1, 8, 4, -1);
    chk("lucas_R7_is_29", 32'(rf[7]), 32'd29);
    run(16'd0, 16'd1, 12, -1, 5);
    run(16'd3, 16'd4, 6, -1, -1);
`ifdef FIBSEQ_OVF_STOP_EN
    run(16'd0, 16'd1, 40, -1, -1);
    chk("F25_wrapped_in_R9", 32'(rf[9]), 32'd9489);
`endif
    for (int r = 0; r < 8; r++)
      run(16'($urandom), 16'($urandom), int'($urandom_range(0, 40)), -1, -1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Parametrised control sequencer that loads two seed values into the register file, then issues a run of ADD operations so that each register receives the sum of the two previously written registers. It sits beside the register file, ALU and bus buffers of the basic CPU datapath and drives their select/enable lines directly. It adds a start/done handshake, run-time seeds and term count, and register-index wrap-around for runs longer than the register file.

## Interface
- DATA_W, 16: width of seeds and `initialR`.
- REG_AW, 4: register-file address width; the register file holds 2^REG_AW registers.
- CNT_W, 8: width of `count`.
- OP_W, 8: width of `ALUOp`. Encodings come from the shared opcode include (`NOP`, `ADD`).

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored unless IDLE.
- seed0  in  DATA_W  first term; latched when `start` is accepted.
- seed1  in  DATA_W  second term; latched when `start` is accepted.
- count  in  CNT_W  total terms to write, including seeds; latched when `start` is accepted.
- aluCarry  in  1  ALU carry-out for the current operation. Used only when the macro is enabled.
- initialR  out  DATA_W  immediate value driven onto the register-file write bus.
- regWrite  out  REG_AW  write select.
- regRead1  out  REG_AW  read select A, the newer operand.
- regRead2  out  REG_AW  read select B, the older operand.
- ALUOp  out  OP_W  ALU operation.
- buffCtrl  out  4  bus-buffer control: 4'b0001 selects the immediate path, 4'b1110 selects the ALU path, 4'b0000 means no driver.
- regWriteEn  out  1  register-file write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- ovf  out  1  overflow flag. Present only with the macro; held until the next start or reset.

## Operation
- States: IDLE, SEED0, SEED1, ADD, DONE. Outputs are a Moore decode of the registered state, the term counter `k` and the latched seeds; no input reaches an output combinationally.
- Transitions out of IDLE, when `start`=1:
  - latch seeds and count, clear `k`;
  - go to DONE if count=0, otherwise go to SEED0.
- SEED0:
  - outputs: `initialR`=seed0, `regWrite`=0, `buffCtrl`=0001, `ALUOp`=NOP, `regWriteEn`=1;
  - next state: DONE if count=1, otherwise SEED1.
- SEED1:
  - outputs: as SEED0, but `initialR`=seed1 and `regWrite`=1;
  - next state: DONE if count=2, otherwise ADD with k=2.
- ADD, writing term k:
  - `regWrite`=k mod 2^REG_AW, `regRead1`=(k-1) mod 2^REG_AW, `regRead2`=(k-2) mod 2^REG_AW;
  - `ALUOp`=ADD, `buffCtrl`=1110, `regWriteEn`=1, `initialR`=0;
  - k increments each cycle; after the term with k=count-1, go to DONE.
- Index arithmetic is REG_AW-bit modular, so indices wrap naturally: term 16 with REG_AW=4 writes R0 from R15 and R14.
- Data sums wrap at DATA_W bits inside the ALU. The sequencer performs no data arithmetic.
- DONE: `done`=1 and `regWriteEn`=0 for exactly one cycle, then IDLE.
- IDLE and DONE drive `regWrite`/`regRead1`/`regRead2`=0, `ALUOp`=NOP, `buffCtrl`=0000, `initialR`=0.
- `start` asserted outside IDLE is ignored. It is not queued.

## Timing
- Reset values: state IDLE, k=0, latched seeds and count 0, every output 0 except `ALUOp`=NOP. `ovf`=0 when the macro is present.
- Reset mid-run: the next cycle is IDLE with reset values and no write enable; any partial run is abandoned.
- Cycle numbering: `start` is sampled at edge E0, and cycle n is the cycle following edge En-1.
  - SEED0 occupies cycle 1.
  - For count≥2, ADD occupies cycles 3..count.
  - `done` is high in cycle count+1 for count≥1, and in cycle 1 for count=0.
- Each write commits at the rising edge that ends the cycle in which `regWriteEn`=1.
- The next `start` is accepted at the earliest in the cycle after DONE, in IDLE.
- `busy` covers SEED0 through DONE inclusive.

## Configuration
- `FIBSEQ_OVF_STOP_EN` defined:
  - `aluCarry` is sampled at the end of each ADD cycle.
  - If it is 1, the write for that term still commits, the next state is DONE regardless of the remaining count, and `ovf` is set.
  - `ovf` clears on accepted `start` or on reset.
- Not defined: `aluCarry` is ignored, the `ovf` port is absent, and runs always complete `count` terms with wrapping sums.

## Test plan
- count=10, seeds 0/1, REG_AW=4: writes R0..R9 in cycles 1..10, and R9 holds 34. `done` is high in cycle 11 only.
- count=20, REG_AW=4: term 16 writes R0 with reads R15/R14. Term 19 writes R3, and R3 holds 4181. `done` is high in cycle 21.
- count=0, then count=1, then count=2: `done` is high in cycle 1 with no writes; in cycle 2 with R0=seed0 only; in cycle 3 with R0/R1 written.
- Seeds 2/1, count=8: Lucas run, R7=29. A `start` pulse during cycle 4 is ignored and the run is unchanged.
- Reset asserted in cycle 5 of a count=12 run: cycle 6 is IDLE, `regWriteEn`=0 and `busy`=0. A fresh start then runs normally.
- With `FIBSEQ_OVF_STOP_EN`, DATA_W=16, seeds 0/1, count=40: carry first occurs writing term 25 (F25=75025). That write commits, `done` follows next cycle, and `ovf`=1 until the next start.
